vector_seq: RTL and testbench
=============================

VECTOR_SEQ -- requirements
Module: vector_seq

Interface
REQ-001 Parameter LEN_W, default 8: width of the vector-length input.
REQ-002 CLK  in  1  sole clock; all state changes on its rising edge.
REQ-003 Reset  in  1  asynchronous, active-high reset.
REQ-004 Start  in  1  launch request; sampled only in IDLE.
REQ-005 Op  in  4  ALU operation code (0 add, 1 sub, 2 and, 3 or); latched at launch.
REQ-006 BaseA, BaseB, BaseD  in  16 each  word base addresses of source A, source B and destination vectors; latched at launch.
REQ-007 Len  in  LEN_W  element count; latched at launch.
REQ-008 Busy  out  1  high in every state except IDLE.
REQ-009 Done  out  1  one-cycle completion pulse.
REQ-010 MemAddr  out  16  word address to the synchronous data memory.
REQ-011 MemRdData  in  16  read data, valid one cycle after MemAddr is presented.
REQ-012 MemWrData  out  16  write data; MemWE  out  1  write enable.
REQ-013 AluA, AluB  out  16  registered operands to the downstream ALU; AluOp  out  4  latched Op.
REQ-014 AluOut  in  16  combinational ALU result.

Function
REQ-015 FSM states: IDLE, RDA, RDB, EXE, WR, DONE.
REQ-016 IDLE with Start=1 -> RDA if Len!=0; -> DONE if Len=0 (no memory access).
REQ-017 RDA: MemAddr=BaseA+i; -> RDB.
REQ-018 RDB: MemAddr=BaseB+i; AluA <= MemRdData; -> EXE.
REQ-019 EXE: AluB <= MemRdData; MemWE=0; -> WR.
REQ-020 WR: MemAddr=BaseD+i, MemWrData=AluOut, MemWE=1; i <= i+1; -> DONE if i+1==Len, else RDA.
REQ-021 DONE: Done=1 for exactly this cycle; -> IDLE.
REQ-022 Throughput: 4 cycles per element; Done is high 4*Len+1 cycles after the launch edge (1 cycle when Len=0).
REQ-023 Address sums are 16-bit modulo; BaseX+i wraps 0xFFFF -> 0x0000 silently.
REQ-024 The element index i is LEN_W bits wide; Len = 2^LEN_W-1 is the maximum vector length.
REQ-025 Start while Busy is ignored; the latched Op, bases and Len are immune to input changes until IDLE.
REQ-026 MemWE is high only in WR; MemAddr=0 and MemWrData=0 in IDLE and DONE.
REQ-027 Op codes 4-15 are passed through to AluOp unchanged; the sequencer still writes AluOut.
REQ-028 Overlapping source and destination regions: element i is written only after elements A[i] and B[i] are read; no other ordering guarantee.

Reset
REQ-029 Reset forces IDLE and i=0 immediately, independent of CLK.
REQ-030 Reset values: Busy=0, Done=0, MemWE=0, MemAddr=0, MemWrData=0, AluA=0, AluB=0, AluOp=0.
REQ-031 Reset during WR aborts the write; MemWE falls asynchronously and no further access occurs.

Configuration
REQ-032 Macro VSEQ_ABORT_EN: when defined, add input Abort (1 bit); Abort=1 in RDA/RDB/EXE -> DONE with no write; Abort=1 in WR completes that write, then -> DONE.
REQ-033 When VSEQ_ABORT_EN is undefined, the Abort port does not exist and every launched vector runs to Len.

Structure
REQ-034 Shared package vseq_pkg holds the state enumeration, the ALU op-code constants (ADD=0, SUB=1, AND=2, OR=3) and the 16-bit word width.
REQ-035 Sub-module vseq_addr_gen holds the index counter and the three base+i adders, and selects MemAddr by state.

Verification
REQ-036 Add: A@0x10={1,2,3}, B@0x20={10,20,30}, Op=0, Len=3, D=0x30 -> mem[0x30..0x32]={11,22,33}; Done is high 13 cycles after launch.
REQ-037 Sub underflow: A={0}, B={1}, Op=1, Len=1 -> D[0]=0xFFFF.
REQ-038 Len=0, Start=1 -> Done is high on the next cycle; MemWE never asserts; Busy high for 1 cycle.
REQ-039 Wrap: BaseD=0xFFFF, Len=2 -> writes land at 0xFFFF then 0x0000.
REQ-040 Reset pulse mid-WR on element 1 of Len=4 -> MemWE=0 at once, state IDLE, and no Done pulse.
REQ-041 Start re-asserted while Busy with new Op -> ignored; results match the original Op (with VSEQ_ABORT_EN: Abort in RDB of element 2 -> exactly 2 writes, then Done).

Source files
------------

// File: rtl/vseq_pkg.sv
// Shared types and constants for the vector sequencer: FSM state encoding,
// ALU op codes and the data-word width.
package vseq_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RDA,
    S_RDB,
    S_EXE,
    S_WR,
    S_DONE
  } state_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;

endpackage

// File: rtl/vseq_addr_gen.sv
// Element index counter and base+index address generation for the vector
// sequencer; drives the memory address according to the current state.
module vseq_addr_gen
  import vseq_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  state_t           state,
  input  word_t            base_a,
  input  word_t            base_b,
  input  word_t            base_d,
  input  logic [LEN_W-1:0] len,
  output word_t            mem_addr,
  output logic             last
);

  logic [LEN_W-1:0] idx;
  logic [LEN_W:0]   idx_next;
  word_t            idx_w;

  // One spare bit keeps the i+1 == len test exact at the maximum length.
  assign idx_next = {1'b0, idx} + {{LEN_W{1'b0}}, 1'b1};
  assign last     = (idx_next == {1'b0, len});
  assign idx_w    = word_t'(idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
    end else if (state == S_IDLE) begin
      idx <= '0;
    end else if (state == S_WR) begin
      idx <= idx_next[LEN_W-1:0];
    end
  end

  // Address sums wrap modulo 2^16 by construction of the 16-bit result.
  always_comb begin
    // NOTE: default assigned first so no path through the case leaves mem_addr unassigned (no latch).
    mem_addr = '0;
    unique case (state)
      S_RDA:   mem_addr = base_a + idx_w;
      S_RDB:   mem_addr = base_b + idx_w;
      S_WR:    mem_addr = base_d + idx_w;
      default: mem_addr = '0;
    endcase
  end

endmodule

// File: rtl/vector_seq.sv
// Vector sequencer: reads A[i], B[i], feeds a downstream ALU, writes D[i].
// Optional feature: define VSEQ_ABORT_EN to add the abort input.
module vector_seq
  import vseq_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [15:0]      base_a,
  input  logic [15:0]      base_b,
  input  logic [15:0]      base_d,
  input  logic [LEN_W-1:0] len,
`ifdef VSEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [15:0]      mem_addr,
  input  logic [15:0]      mem_rd_data,
  output logic [15:0]      mem_wr_data,
  output logic             mem_we,
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  output logic [3:0]       alu_op,
  input  logic [15:0]      alu_out
);

  state_t           state, state_next;
  logic [3:0]       op_q;
  word_t            base_a_q, base_b_q, base_d_q;
  logic [LEN_W-1:0] len_q;
  logic             last;

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Launch parameters are captured only from IDLE, so a start while busy is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      base_d_q <= '0;
      len_q    <= '0;
    end else if (state == S_IDLE && start) begin
      op_q     <= op;
      base_a_q <= base_a;
      base_b_q <= base_b;
      base_d_q <= base_d;
      len_q    <= len;
    end
  end

  // Read data arrives one cycle after its address: A[i] in RDB, B[i] in EXE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a <= '0;
      alu_b <= '0;
    end else begin
      if (state == S_RDB) alu_a <= mem_rd_data;
      if (state == S_EXE) alu_b <= mem_rd_data;
    end
  end

  assign alu_op = op_q;

  vseq_addr_gen #(.LEN_W(LEN_W)) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .state    (state),
    .base_a   (base_a_q),
    .base_b   (base_b_q),
    .base_d   (base_d_q),
    .len      (len_q),
    .mem_addr (mem_addr),
    .last     (last)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (start) state_next = (len != '0) ? S_RDA : S_DONE;
      S_RDA:   state_next = S_RDB;
      S_RDB:   state_next = S_EXE;
      S_EXE:   state_next = S_WR;
      S_WR:    state_next = last ? S_DONE : S_RDA;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
`ifdef VSEQ_ABORT_EN
    // An abort during WR lets the current write complete before finishing.
    if (abort && state inside {S_RDA, S_RDB, S_EXE, S_WR}) state_next = S_DONE;
`endif
  end

  // Outputs decode the state register directly, so reset drops mem_we at once.
  always_comb begin
    busy        = (state != S_IDLE);
    done        = (state == S_DONE);
    mem_we      = (state == S_WR);
    mem_wr_data = mem_we ? alu_out : '0;
  end

endmodule

// File: tb/tb_vector_seq.sv
// Directed self-checking bench for vector_seq with a synchronous memory
// model and a reference ALU (ops 4-15 modelled as XOR).
module tb_vector_seq;
  import vseq_pkg::*;

  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             reset, start;
  logic [3:0]       op;
  logic [15:0]      base_a, base_b, base_d;
  logic [LEN_W-1:0] len;
`ifdef VSEQ_ABORT_EN
  logic             abort;
`endif
  logic             busy, done, mem_we;
  logic [15:0]      mem_addr, mem_rd_data, mem_wr_data;
  logic [15:0]      alu_a, alu_b, alu_out;
  logic [3:0]       alu_op;

  logic [15:0] mem [0:65535];
  logic        ld_we;
  logic [15:0] ld_addr, ld_data;

  int checks = 0;
  int errors = 0;
  int we_count = 0;
  int done_count = 0;

  always #5 clk = ~clk;

  vector_seq #(.LEN_W(LEN_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .base_a      (base_a),
    .base_b      (base_b),
    .base_d      (base_d),
    .len         (len),
`ifdef VSEQ_ABORT_EN
    .abort       (abort),
`endif
    .busy        (busy),
    .done        (done),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_data (mem_wr_data),
    .mem_we      (mem_we),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_out     (alu_out)
  );

  always @(posedge clk) begin
    if (mem_we)     mem[mem_addr] <= mem_wr_data;
    else if (ld_we) mem[ld_addr]  <= ld_data;
    mem_rd_data <= mem[mem_addr];
    if (mem_we) we_count   <= we_count + 1;
    if (done)   done_count <= done_count + 1;
  end

  always_comb begin
    case (alu_op)
      OP_ADD:  alu_out = alu_a + alu_b;
      OP_SUB:  alu_out = alu_a - alu_b;
      OP_AND:  alu_out = alu_a & alu_b;
      OP_OR:   alu_out = alu_a | alu_b;
      default: alu_out = alu_a ^ alu_b;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [15:0] addr, input logic [15:0] data);
    @(negedge clk);
    ld_we = 1'b1; ld_addr = addr; ld_data = data;
    @(posedge clk);
    #1 ld_we = 1'b0;
  endtask

  // Returns one step after the launch edge, i.e. during cycle 1 of the run.
  task automatic launch(input logic [3:0] o, input logic [15:0] ba, input logic [15:0] bb,
                        input logic [15:0] bd, input logic [LEN_W-1:0] l);
    @(negedge clk);
    op = o; base_a = ba; base_b = bb; base_d = bd; len = l; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (done !== 1'b1 && n < 1200) begin
      @(posedge clk);
      #1 n++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, w0, d0;
    reset = 1'b1; start = 1'b0; op = '0; len = '0;
    base_a = '0; base_b = '0; base_d = '0;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;
`ifdef VSEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wr_data, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_op, 0);
    @(negedge clk) reset = 1'b0;

    // Add, Len=3
    poke(16'h0010, 16'd1);  poke(16'h0011, 16'd2);  poke(16'h0012, 16'd3);
    poke(16'h0020, 16'd10); poke(16'h0021, 16'd20); poke(16'h0022, 16'd30);
    w0 = we_count;
    launch(OP_ADD, 16'h0010, 16'h0020, 16'h0030, 8'd3);
    check("add_busy", busy, 1);
    wait_done(n);
    check("add_done", done, 1);
    check("add_latency", n, 13);
    @(posedge clk); #1;
    check("add_idle_busy", busy, 0);
    check("add_idle_done", done, 0);
    check("add_d0", mem[16'h0030], 16'd11);
    check("add_d1", mem[16'h0031], 16'd22);
    check("add_d2", mem[16'h0032], 16'd33);
    check("add_writes", we_count - w0, 3);

    // Sub underflow, Len=1
    poke(16'h0060, 16'd0); poke(16'h0061, 16'd1);
    launch(OP_SUB, 16'h0060, 16'h0061, 16'h0070, 8'd1);
    wait_done(n);
    check("sub_latency", n, 5);
    @(posedge clk); #1;
    check("sub_d0", mem[16'h0070], 16'hFFFF);

    // Len=0: immediate Done, no memory access
    w0 = we_count;
    launch(OP_ADD, 16'h0000, 16'h0000, 16'h0100, 8'd0);
    check("len0_done", done, 1);
    check("len0_busy", busy, 1);
    check("len0_we", mem_we, 0);
    check("len0_addr", mem_addr, 0);
    @(posedge clk); #1;
    check("len0_busy_after", busy, 0);
    check("len0_done_after", done, 0);
    check("len0_writes", we_count - w0, 0);

    // Destination wrap 0xFFFF -> 0x0000
    poke(16'h0080, 16'd7); poke(16'h0081, 16'd8);
    poke(16'h0090, 16'd1); poke(16'h0091, 16'd1);
    poke(16'hFFFF, 16'hDEAD); poke(16'h0000, 16'hDEAD);
    launch(OP_ADD, 16'h0080, 16'h0090, 16'hFFFF, 8'd2);
    wait_done(n);
    check("wrap_done", done, 1);
    @(posedge clk); #1;
    check("wrap_d_ffff", mem[16'hFFFF], 16'd8);
    check("wrap_d_0000", mem[16'h0000], 16'd9);

    // Unlisted op code passes through to the ALU
    poke(16'h00C0, 16'h00FF); poke(16'h00C1, 16'h0F0F);
    launch(4'hC, 16'h00C0, 16'h00C1, 16'h00C8, 8'd1);
    check("op_pass", alu_op, 4'hC);
    wait_done(n);
    @(posedge clk); #1;
    check("op_pass_d0", mem[16'h00C8], 16'h0FF0);

    // Start while busy with a different op and destination is ignored
    poke(16'h0040, 16'd5); poke(16'h0041, 16'd6);
    poke(16'h0050, 16'd1); poke(16'h0051, 16'd2);
    poke(16'h00A0, 16'h5555); poke(16'h00A1, 16'h5555); poke(16'h00B0, 16'h5555);
    launch(OP_OR, 16'h0040, 16'h0050, 16'h00A0, 8'd2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = OP_SUB; base_d = 16'h00B0; len = 8'd1;
    @(negedge clk);
    start = 1'b0;
    check("restart_op", alu_op, OP_OR);
    wait_done(n);
    check("restart_done", done, 1);
    @(posedge clk); #1;
    check("restart_d0", mem[16'h00A0], 16'd5);
    check("restart_d1", mem[16'h00A1], 16'd6);
    check("restart_other", mem[16'h00B0], 16'h5555);

    // Reset pulse during WR of element 1 of a Len=4 vector
    for (int k = 0; k < 4; k++) begin
      poke(16'h00D0 + 16'(k), 16'(k + 1));
      poke(16'h00E0 + 16'(k), 16'd1);
      poke(16'h00F0 + 16'(k), 16'h5555);
    end
    d0 = done_count;
    launch(OP_ADD, 16'h00D0, 16'h00E0, 16'h00F0, 8'd4);
    repeat (7) @(posedge clk);
    #1;
    check("midwr_we", mem_we, 1);
    check("midwr_addr", mem_addr, 16'h00F1);
    #2 reset = 1'b1;
    #1;
    check("rstwr_we", mem_we, 0);
    check("rstwr_busy", busy, 0);
    check("rstwr_addr", mem_addr, 0);
    check("rstwr_alu_a", alu_a, 0);
    @(negedge clk) reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("rstwr_no_done", done_count - d0, 0);
    check("rstwr_idle", busy, 0);
    check("rstwr_d0", mem[16'h00F0], 16'd2);
    check("rstwr_d1", mem[16'h00F1], 16'h5555);

`ifdef VSEQ_ABORT_EN
    // Abort in RDB of element 2: exactly two writes, then Done
    w0 = we_count;
    launch(OP_ADD, 16'h00D0, 16'h00E0, 16'h0100, 8'd4);
    repeat (9) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_done", done, 1);
    check("abort_writes", we_count - w0, 2);
    @(posedge clk); #1;
    check("abort_idle", busy, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
